// File: rtl/mux_nch_reg_pkg.sv
// Shared definitions for the N-channel registered multiplexer.
//   MODE_DIRECT / MODE_RR : values of the mode input
//   clog2()               : ceil(log2(n)) for elaboration-time widths
package mux_nch_reg_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : per-channel request
//   ptr     : last channel served; scanning starts at ptr+1, ptr is scanned last
//   gnt_vld : some request was found
//   gnt_idx : index of the granted channel (0 when gnt_vld=0)
module rr_arbiter #(
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_vld,
  output logic [SELW-1:0] gnt_idx
);

  int c;

  // Walk offsets from farthest to nearest so the nearest requester after
  // ptr is the last one written and therefore wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int k = NCH; k >= 1; k--) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      if (req[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel, WIDTH-bit multiplexer with a registered output stage.
//   clk, rst_n  : clock, async active-low reset
//   mode        : MODE_DIRECT (sel picks channel) / MODE_RR (fair arbitration)
//   sel         : directed-mode channel; sel >= NCH grants nothing
//   in_data     : channel i at [i*WIDTH +: WIDTH]
//   in_valid    : per-channel valid
//   in_ready    : one-hot (or zero) ready to the granted channel
//   out_data    : registered selected word
//   out_ch      : channel the registered word came from
//   out_valid   : output register holds data
//   out_ready   : downstream accepts
module mux_nch_reg
  import mux_nch_reg_pkg::*;
#(
  parameter  int NCH   = 8,
  parameter  int WIDTH = 32,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [NCH-1:0][WIDTH-1:0] lanes;
  logic [SELW-1:0]           rr_ptr;
  logic [SELW-1:0]           rr_idx;
  logic [SELW-1:0]           gnt_idx;
  logic                      rr_vld;
  logic                      dir_vld;
  logic                      grant;
  logic                      load_en;
  logic                      xfer;

  assign lanes = in_data;

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_vld (rr_vld),
    .gnt_idx (rr_idx)
  );

  // Directed path: out-of-range selects (non power-of-2 NCH) never grant.
  always_comb begin
    dir_vld = 1'b0;
    if (int'(sel) < NCH) dir_vld = in_valid[sel];
  end

  assign grant   = (mode == MODE_RR) ? rr_vld : dir_vld;
  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;
  assign load_en = !out_valid || out_ready;
  // Gate with rst_n so nothing is offered upstream while held in reset.
  assign xfer    = rst_n && load_en && grant;

  for (genvar i = 0; i < NCH; i++) begin : g_rdy
    assign in_ready[i] = xfer && (gnt_idx == SELW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(NCH - 1);
    end else if (xfer) begin
      // A load on the same edge as a drain replaces the word, no bubble.
      out_valid <= 1'b1;
      out_data  <= lanes[gnt_idx];
      out_ch    <= gnt_idx;
      if (mode == MODE_RR) rr_ptr <= gnt_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nch_reg.sv
module tb_mux_nch_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  always #5 clk = ~clk;

  // 8-channel instance
  logic         mode;
  logic [2:0]   sel;
  logic [255:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  // 6-channel instance (non power-of-2 boundary)
  logic         mode6;
  logic [2:0]   sel6;
  logic [191:0] in_data6;
  logic [5:0]   in_valid6;
  logic [5:0]   in_ready6;
  logic [31:0]  out_data6;
  logic [2:0]   out_ch6;
  logic         out_valid6;
  logic         out_ready6;

  mux_nch_reg #(.NCH(8), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nch_reg #(.NCH(6), .WIDTH(32)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .in_data(in_data6),
    .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
    .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(out_ready6)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the 8-channel instance
  bit          m_vld;
  logic [31:0] m_data;
  int          m_ch;
  int          m_ptr;

  function automatic int grant8(bit md, int s, logic [7:0] v, int ptr);
    if (!md) return (s < 8 && v[s]) ? s : -1;
    for (int k = 1; k <= 8; k++)
      if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready();
    logic [7:0] r;
    int g;
    r = '0;
    g = grant8(mode, int'(sel), in_valid, m_ptr);
    if (rst_n && (!m_vld || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_data = '0; m_ch = 0; m_ptr = 7;
  endtask

  task automatic tick();
    int g;
    g = grant8(mode, int'(sel), in_valid, m_ptr);
    if ((!m_vld || out_ready) && g >= 0) begin
      m_data = in_data[g*32 +: 32];
      m_ch   = g;
      m_vld  = 1;
      if (mode) m_ptr = g;
    end else if (m_vld && out_ready) begin
      m_vld = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 6; i++) in_data6[i*32 +: 32] = $urandom;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 0; mode = 1; sel = 0; in_valid = 8'hFF; out_ready = 1;
    rand_data();
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 8'h00 || out_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold got vld=%b rdy=%h data=%h want 0/00/0", out_valid, in_ready, out_data);
      end
    end
    rst_n = 1; #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++; $display("FAIL reset_first_ready got %h want 01", in_ready);
    end
    d = in_data[31:0];
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== d) begin
      errors++;
      $display("FAIL reset_first_xfer got vld=%b ch=%0d data=%h want 1/0/%h", out_valid, out_ch, out_data, d);
    end
  endtask

  task automatic test_directed();
    mode = 0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1;
    rand_data();
    in_data[5*32 +: 32] = 32'hA5A5_0005;
    #1;
    checks++;
    if (in_ready !== 8'h20) begin
      errors++; $display("FAIL directed_ready got %h want 20", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 3'd5 || out_data !== 32'hA5A5_0005) begin
      errors++;
      $display("FAIL directed_out got vld=%b ch=%0d data=%h want 1/5/a5a50005", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_rr_fair();
    int seq [8] = '{1, 2, 4, 7, 1, 2, 4, 7};
    logic [31:0] d;
    logic [7:0]  one;
    mode = 1; in_valid = 8'b1001_0110; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      #1;
      one = 8'h01 << seq[i];
      checks++;
      if (in_ready !== one || in_ready !== exp_ready()) begin
        errors++; $display("FAIL rr_ready[%0d] got %h want %h", i, in_ready, one);
      end
      d = in_data[seq[i]*32 +: 32];
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_ch) != seq[i] || out_data !== d) begin
        errors++;
        $display("FAIL rr_seq[%0d] got vld=%b ch=%0d data=%h want 1/%0d/%h", i, out_valid, out_ch, out_data, seq[i], d);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    out_ready = 0; in_valid = 8'hFF; mode = 1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      #1;
      checks++;
      if (in_ready !== 8'h00) begin
        errors++; $display("FAIL stall_ready[%0d] got %h want 00", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 3'd7 || out_data !== m_data) begin
        errors++;
        $display("FAIL stall_hold[%0d] got vld=%b ch=%0d data=%h want 1/7/%h", i, out_valid, out_ch, out_data, m_data);
      end
    end
    out_ready = 1; #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++; $display("FAIL stall_release_ready got %h want 01", in_ready);
    end
    d = in_data[31:0];
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== d) begin
      errors++;
      $display("FAIL stall_release_load got vld=%b ch=%0d data=%h want 1/0/%h", out_valid, out_ch, out_data, d);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom);
      sel       = 3'($urandom);
      in_valid  = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      rand_data();
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got %h want %h", i, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_vld || int'(out_ch) != m_ch || out_data !== m_data) begin
        errors++;
        $display("FAIL rand_out[%0d] got vld=%b ch=%0d data=%h want %b/%0d/%h", i, out_valid, out_ch, out_data, m_vld, m_ch, m_data);
      end
    end
  endtask

  task automatic test_boundary6();
    logic [31:0] d;
    in_valid = 8'h00; out_ready = 1;
    mode6 = 0; sel6 = 3'd2; in_valid6 = 6'h3F; out_ready6 = 1;
    rand_data();
    d = in_data6[2*32 +: 32];
    #1;
    checks++;
    if (in_ready6 !== 6'b000100) begin
      errors++; $display("FAIL b6_dir_ready got %h want 04", in_ready6);
    end
    tick();
    checks++;
    if (out_valid6 !== 1'b1 || out_ch6 !== 3'd2 || out_data6 !== d) begin
      errors++;
      $display("FAIL b6_dir_out got vld=%b ch=%0d data=%h want 1/2/%h", out_valid6, out_ch6, out_data6, d);
    end
    sel6 = 3'd7; #1;
    checks++;
    if (in_ready6 !== 6'b000000) begin
      errors++; $display("FAIL b6_sel7_ready got %h want 00", in_ready6);
    end
    tick();
    checks++;
    if (out_valid6 !== 1'b0 || out_ch6 !== 3'd2 || out_data6 !== d) begin
      errors++;
      $display("FAIL b6_sel7_drain got vld=%b ch=%0d data=%h want 0/2/%h", out_valid6, out_ch6, out_data6, d);
    end
    mode6 = 1; in_valid6 = 6'b100000; #1;
    checks++;
    if (in_ready6 !== 6'b100000) begin
      errors++; $display("FAIL b6_rr5_ready got %h want 20", in_ready6);
    end
    tick();
    checks++;
    if (out_ch6 !== 3'd5 || out_valid6 !== 1'b1) begin
      errors++; $display("FAIL b6_rr5_out got ch=%0d vld=%b want 5/1", out_ch6, out_valid6);
    end
    in_valid6 = 6'b000001; #1;
    checks++;
    if (in_ready6 !== 6'b000001) begin
      errors++; $display("FAIL b6_wrap_ready got %h want 01", in_ready6);
    end
    d = in_data6[31:0];
    tick();
    checks++;
    if (out_ch6 !== 3'd0 || out_data6 !== d || out_valid6 !== 1'b1) begin
      errors++;
      $display("FAIL b6_wrap_out got ch=%0d data=%h vld=%b want 0/%h/1", out_ch6, out_data6, out_valid6, d);
    end
    in_valid6 = 6'h00;
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    mode = 1; in_valid = 8'hFF; out_ready = 1;
    rand_data();
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got vld=%b want 1", out_valid);
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 3'd0 || in_ready !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async got vld=%b data=%h ch=%0d rdy=%h want 0/0/0/00", out_valid, out_data, out_ch, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1; #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++; $display("FAIL midrst_restart_ready got %h want 01", in_ready);
    end
    d = in_data[31:0];
    tick();
    checks++;
    if (out_ch !== 3'd0 || out_data !== d || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart_out got ch=%0d data=%h vld=%b want 0/%h/1", out_ch, out_data, out_valid, d);
    end
  endtask

  initial begin
    rst_n = 0; mode = 0; sel = 0; in_data = '0; in_valid = '0; out_ready = 0;
    mode6 = 0; sel6 = 0; in_data6 = '0; in_valid6 = '0; out_ready6 = 1;
    test_reset();
    test_directed();
    test_rr_fair();
    test_backpressure();
    test_random();
    test_boundary6();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
